// File: rtl/uart_tx.sv
// UART transmitter: one word per valid/ready handshake, serialised as
// start bit, DATA_WIDTH data bits LSB first, optional parity, 1 or 2 stop bits.
// Every bit is held for CLKS_PER_BIT clocks; tx is a registered output that
// idles high.
module uart_tx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_WIDTH = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W        = $clog2(DATA_WIDTH + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  // Reject configurations that cannot time a bit or frame correctly.
  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $fatal(1, "uart_tx: CLKS_PER_BIT must be at least 2");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
    $fatal(1, "uart_tx: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Parity of the captured word; odd parity is the inverted even parity.
  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d,
                                       input logic odd);
    return (^d) ^ odd;
  endfunction

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  parity_q, parity_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;
  logic                  bit_tick;

  assign bit_tick = (cnt_q == CNT_LAST);
  assign tx_ready = (state_q == S_IDLE);
  assign busy     = ~tx_ready;
  assign tx       = tx_q;
  assign done     = done_q;

  // Next-state, counters and the next registered line level.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    done_d   = 1'b0;
    tx_d     = 1'b1;

    // The bit-period counter only runs while a frame is on the line.
    if (state_q == S_IDLE) begin
      cnt_d = '0;
    end else if (bit_tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          // Parity is taken now because the shift register is consumed later.
          shift_d  = tx_data;
          parity_d = calc_parity(tx_data, (PARITY_ODD != 0));
          idx_d    = '0;
          state_d  = S_START;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_START: begin
        if (bit_tick) begin
          state_d = S_DATA;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1'b1;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_d   = idx_q + 1'b1;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_PARITY: begin
        if (bit_tick) begin
          state_d = S_STOP;
        end else begin
          state_d = S_PARITY;
        end
      end
      S_STOP: begin
        // idx_q counts stop bits here.
        if (bit_tick) begin
          if (idx_q == STOP_LAST) begin
            idx_d   = '0;
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + 1'b1;
          end
        end else begin
          state_d = S_STOP;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase

    // Line level follows the state being entered so tx stays registered
    // and the first transition appears one cycle after the handshake.
    case (state_d)
      S_IDLE:   tx_d = 1'b1;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = parity_d;
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  // State and datapath registers; reset leaves the line idling high.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances (8N1, 8E1, 8O1, 8N2) driven from
// a table of frames with hand-computed line patterns, plus hand-written reset
// sequences.
module tb_uart_tx;

  localparam int C = 868;

  logic       clk = 1'b0;
  logic [3:0] rst_n_r;
  logic [3:0] valid_r;
  logic [7:0] data_r [4];
  logic [3:0] tx_w, rdy_w, busy_w, done_w;

  int n_checks = 0;
  int n_fail   = 0;

  // One frame record: bits[i] is the expected line level in bit period i.
  typedef struct {
    int         grp;
    int         k;
    logic [7:0] d;
    logic [11:0] bits;
    int         n;
    bit         hold;
    int         inj;
    int         idle;
  } vec_t;

  vec_t tbl [7];

  // 10 ns system clock shared by every instance.
  always #5 clk = ~clk;

  uart_tx u_8n1 (.clock(clk), .reset_n(rst_n_r[0]), .tx_data(data_r[0]), .tx_valid(valid_r[0]),
                 .tx_ready(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));
  uart_tx #(.PARITY_EN(1), .PARITY_ODD(0)) u_8e1 (.clock(clk), .reset_n(rst_n_r[1]), .tx_data(data_r[1]),
                 .tx_valid(valid_r[1]), .tx_ready(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));
  uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) u_8o1 (.clock(clk), .reset_n(rst_n_r[2]), .tx_data(data_r[2]),
                 .tx_valid(valid_r[2]), .tx_ready(rdy_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));
  uart_tx #(.STOP_BITS(2)) u_8n2 (.clock(clk), .reset_n(rst_n_r[3]), .tx_data(data_r[3]), .tx_valid(valid_r[3]),
                 .tx_ready(rdy_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .done(done_w[3]));

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Send one word on instance k (called at a negedge) and check the whole frame.
  task automatic run_frame(input int id, input int k, input logic [7:0] d, input logic [11:0] bits,
                           input int n, input bit hold, input int inj, input int idle);
    int wait_c = 0;
    int e_bit = 0, e_done = 0, e_rdy = 0, e_idle = 0;
    int first_bad = -1;
    int b;
    logic [7:0] dec = 8'h00;
    while (!rdy_w[k] && wait_c < 20000) begin
      @(negedge clk);
      wait_c++;
    end
    check($sformatf("v%0d ready_before_send", id), int'(rdy_w[k]), 1);
    data_r[k]  = d;
    valid_r[k] = 1'b1;
    @(posedge clk);
    for (int j = 1; j <= n * C + 1; j++) begin
      @(negedge clk);
      if (j == 1 && !hold) valid_r[k] = 1'b0;
      if (inj > 0 && j == inj) begin
        valid_r[k] = 1'b1;
        data_r[k]  = 8'h3C;
      end
      if (inj > 0 && j == inj + 3) valid_r[k] = 1'b0;
      if (j <= n * C) begin
        b = (j - 1) / C;
        if (tx_w[k] !== bits[b]) begin
          e_bit++;
          if (first_bad < 0) first_bad = j;
        end
        if (done_w[k] !== 1'b0) e_done++;
        if (rdy_w[k] !== 1'b0 || busy_w[k] !== 1'b1) e_rdy++;
        if (b >= 1 && b <= 8 && ((j - 1) % C) == C / 2) dec[b-1] = tx_w[k];
      end
    end
    if (e_bit != 0) $display("v%0d first bad line cycle H+%0d", id, first_bad);
    check($sformatf("v%0d line_pattern_errors", id), e_bit, 0);
    check($sformatf("v%0d decoded_byte", id), int'(dec), int'(d));
    check($sformatf("v%0d early_done_cycles", id), e_done, 0);
    check($sformatf("v%0d busy_during_frame_errors", id), e_rdy, 0);
    check($sformatf("v%0d done_at_end", id), int'(done_w[k]), 1);
    check($sformatf("v%0d ready_at_end", id), int'(rdy_w[k]), 1);
    check($sformatf("v%0d busy_at_end", id), int'(busy_w[k]), 0);
    check($sformatf("v%0d idle_high_at_end", id), int'(tx_w[k]), 1);
    if (idle > 0) begin
      for (int j = 0; j < idle; j++) begin
        @(negedge clk);
        if (tx_w[k] !== 1'b1 || done_w[k] !== 1'b0 || rdy_w[k] !== 1'b1) e_idle++;
      end
      check($sformatf("v%0d quiet_after_frame", id), e_idle, 0);
    end
  endtask

  initial begin
    int e;
    // grp, inst, data, line pattern (bit period i at bit i), N, hold, inject, idle watch
    tbl[0] = '{0, 0, 8'hA5, 12'h34A, 10, 1'b0, 0, 0};
    tbl[1] = '{0, 0, 8'h00, 12'h200, 10, 1'b1, 0, 0};
    tbl[2] = '{0, 0, 8'hFF, 12'h3FE, 10, 1'b0, 0, 0};
    tbl[3] = '{0, 0, 8'h5A, 12'h2B4, 10, 1'b0, 1 + 3 * C + 100, 2000};
    tbl[4] = '{1, 1, 8'h07, 12'h60E, 11, 1'b0, 0, 0};
    tbl[5] = '{1, 2, 8'h07, 12'h40E, 11, 1'b0, 0, 0};
    tbl[6] = '{1, 3, 8'h81, 12'h702, 11, 1'b0, 0, 0};

    rst_n_r = 4'b0000;
    valid_r = 4'b0000;
    for (int i = 0; i < 4; i++) data_r[i] = 8'h00;
    repeat (5) @(negedge clk);
    rst_n_r = 4'b1111;
    repeat (3) @(negedge clk);

    // Mid-simulation reset of the 8N1 instance: outputs go to idle values at once.
    rst_n_r[0] = 1'b0;
    #1;
    check("reset tx", int'(tx_w[0]), 1);
    check("reset tx_ready", int'(rdy_w[0]), 1);
    check("reset busy", int'(busy_w[0]), 0);
    check("reset done", int'(done_w[0]), 0);
    repeat (3) @(negedge clk);
    rst_n_r[0] = 1'b1;
    @(negedge clk);

    fork
      begin
        for (int i = 0; i < 7; i++)
          if (tbl[i].grp == 0)
            run_frame(i, tbl[i].k, tbl[i].d, tbl[i].bits, tbl[i].n, tbl[i].hold, tbl[i].inj, tbl[i].idle);
      end
      begin
        for (int i = 0; i < 7; i++)
          if (tbl[i].grp == 1)
            run_frame(i, tbl[i].k, tbl[i].d, tbl[i].bits, tbl[i].n, tbl[i].hold, tbl[i].inj, tbl[i].idle);
      end
    join

    // Reset during data bit 3 of 0xF0 (bit 3 is a 0, so the jump to 1 is visible).
    @(negedge clk);
    data_r[0]  = 8'hF0;
    valid_r[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_r[0] = 1'b0;
    for (int j = 2; j <= 1 + 4 * C + C / 2; j++) @(negedge clk);
    check("midreset tx_before", int'(tx_w[0]), 0);
    rst_n_r[0] = 1'b0;
    #1;
    check("midreset tx_now_high", int'(tx_w[0]), 1);
    check("midreset ready", int'(rdy_w[0]), 1);
    check("midreset done", int'(done_w[0]), 0);
    // A request presented during reset must not start a frame.
    data_r[0]  = 8'hFF;
    valid_r[0] = 1'b1;
    e = 0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      if (done_w[0] !== 1'b0 || tx_w[0] !== 1'b1) e++;
    end
    valid_r[0] = 1'b0;
    rst_n_r[0] = 1'b1;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (done_w[0] !== 1'b0 || tx_w[0] !== 1'b1 || rdy_w[0] !== 1'b1) e++;
    end
    check("midreset quiet_after", e, 0);
    run_frame(7, 0, 8'hC3, 12'h386, 10, 1'b0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
